// File: rtl/led_pattern_gen.sv
// led_pattern_gen: stepped LED patterns (flow-left/right, ping-pong, blink-all) paced by a prescaler.
// Optional 4-bit PWM dimming when LED_PATTERN_DIM_EN is defined (adds the dim input).
module led_pattern_gen #(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         mode,
  input  logic               mode_vld,
  input  logic               pause,
`ifdef LED_PATTERN_DIM_EN
  input  logic [3:0]         dim,
`endif
  output logic [LED_NUM-1:0] led,
  output logic               step_tick
);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [1:0] FLOW_L = 2'd0, FLOW_R = 2'd1, PING = 2'd2, BLINK = 2'd3;
  localparam logic [LED_NUM-1:0] ONE  = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] TOP  = ONE << (LED_NUM - 1);
  localparam logic [CW-1:0]      LAST = CW'(STEP_CYCLES - 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_q, dir_d, up;
  logic [LED_NUM-1:0] pat_q, pat_d, nxt, init;
  logic               tick_q, tick_d;
  // Ping-pong turns around on the end bit itself, so the end bit is never shown twice.
  always_comb begin
    up     = dir_q ? !pat_q[LED_NUM-1] : pat_q[0];
    nxt    = mode_q == BLINK  ? {LED_NUM{~pat_q[0]}}
           : LED_NUM == 1     ? pat_q
           : mode_q == FLOW_L ? (pat_q << 1) | (pat_q >> (LED_NUM - 1))
           : mode_q == FLOW_R ? (pat_q >> 1) | (pat_q << (LED_NUM - 1))
           : up               ? pat_q << 1 : pat_q >> 1;
    init   = mode == BLINK ? '1 : mode == FLOW_R ? TOP : ONE;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    tick_d = 1'b0;
    if (mode_vld) begin
      mode_d = mode;
      cnt_d  = '0;
      dir_d  = 1'b1;
      pat_d  = init;
    end else if (!pause) begin
      cnt_d  = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      pat_d  = cnt_q == LAST ? nxt : pat_q;
      dir_d  = cnt_q == LAST && mode_q == PING ? up : dir_q;
      tick_d = cnt_q == LAST;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      mode_q <= FLOW_L;
      dir_q  <= 1'b1;
      pat_q  <= ONE;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      tick_q <= tick_d;
    end
  end
  assign step_tick = tick_q;
`ifdef LED_PATTERN_DIM_EN
  logic [3:0]         pwm_q, pwm_d;
  logic [LED_NUM-1:0] led_q, led_d;
  always_comb begin
    pwm_d = pwm_q + 4'd1;
    led_d = pat_d & {LED_NUM{pwm_q < dim}};
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_q <= '0;
      led_q <= ONE;
    end else begin
      pwm_q <= pwm_d;
      led_q <= led_d;
    end
  end
  assign led = led_q;
`else
  assign led = pat_q;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: vector-table + scoreboard bench for led_pattern_gen (LED_NUM=4, STEP_CYCLES=5).
module tb_led_pattern_gen;
  logic       clk = 1'b0, rst_n = 1'b0, mode_vld = 1'b0, pause = 1'b0, step_tick;
  logic [1:0] mode = 2'd0;
  logic [3:0] led;
`ifdef LED_PATTERN_DIM_EN
  logic [3:0] dim = 4'd0;
`endif
  int n_vec = 0, n_bad = 0;
  typedef struct {logic [1:0] mode; logic vld; logic pause; logic [3:0] led; logic tick;} vec_t;
  typedef struct {logic [3:0] led; logic tick;} exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  led_pattern_gen #(.LED_NUM(4), .STEP_CYCLES(5)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .mode_vld(mode_vld), .pause(pause),
`ifdef LED_PATTERN_DIM_EN
    .dim(dim),
`endif
    .led(led), .step_tick(step_tick)
  );
  function automatic void add(input logic [1:0] m, input logic v, input logic p,
                              input logic [3:0] l, input logic t);
    vecs.push_back('{mode: m, vld: v, pause: p, led: l, tick: t});
  endfunction
  function automatic void hold(input int n, input logic [3:0] l, input logic p);
    for (int i = 0; i < n; i++) add(2'd0, 1'b0, p, l, 1'b0);
  endfunction
  // n cycles of free running: n-1 unchanged, then the step shows b with a tick.
  function automatic void run(input int n, input logic [3:0] a, input logic [3:0] b);
    hold(n - 1, a, 1'b0);
    add(2'd0, 1'b0, 1'b0, b, 1'b1);
  endfunction
  task automatic check(input string name, input logic [3:0] el, input logic et);
    n_vec++;
    if (led !== el || step_tick !== et) begin
      n_bad++;
      $display("FAIL %s: got led=%b tick=%b, expected led=%b tick=%b", name, led, step_tick, el, et);
    end
  endtask
  task automatic cmp(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  task automatic apply_all(input string tag);
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode;
      mode_vld = vecs[i].vld;
      pause = vecs[i].pause;
      sb.push_back('{led: vecs[i].led, tick: vecs[i].tick});
      @(posedge clk);
      #1;
      if (sb.size() == 0) cmp({tag, "_sb_empty"}, 0, 1);
      else begin
        e = sb.pop_front();
        check($sformatf("%s[%0d]", tag, i), e.led, e.tick);
      end
    end
    vecs.delete();
    mode_vld = 1'b0;
    pause = 1'b0;
  endtask
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #12;
    check("reset", 4'b0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef LED_PATTERN_DIM_EN
    begin
      int on;
      dim = 4'd4; pause = 1'b1; mode = 2'd0; mode_vld = 1'b1;
      @(posedge clk); #1;
      mode_vld = 1'b0;
      on = 0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        if (led != 4'b0000) begin
          on++;
          cmp($sformatf("dim4_bit[%0d]", i), int'(led), 1);
        end
      end
      cmp("dim4_duty", on, 4);
      dim = 4'd0;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        cmp($sformatf("dim0[%0d]", i), int'(led), 0);
      end
    end
`else
    run(5, 4'b0001, 4'b0010); run(5, 4'b0010, 4'b0100);
    run(5, 4'b0100, 4'b1000); run(5, 4'b1000, 4'b0001);
    add(2'd2, 1'b1, 1'b0, 4'b0001, 1'b0);
    run(5, 4'b0001, 4'b0010); run(5, 4'b0010, 4'b0100); run(5, 4'b0100, 4'b1000);
    run(5, 4'b1000, 4'b0100); run(5, 4'b0100, 4'b0010); run(5, 4'b0010, 4'b0001);
    run(5, 4'b0001, 4'b0010);
    hold(2, 4'b0010, 1'b0); hold(12, 4'b0010, 1'b1); run(3, 4'b0010, 4'b0100);
    hold(4, 4'b0100, 1'b0); add(2'd1, 1'b1, 1'b0, 4'b1000, 1'b0);
    run(5, 4'b1000, 4'b0100); run(5, 4'b0100, 4'b0010);
    run(5, 4'b0010, 4'b0001); run(5, 4'b0001, 4'b1000);
    add(2'd0, 1'b1, 1'b1, 4'b0001, 1'b0); hold(6, 4'b0001, 1'b1); run(5, 4'b0001, 4'b0010);
    hold(2, 4'b0010, 1'b0); add(2'd0, 1'b1, 1'b0, 4'b0001, 1'b0); run(5, 4'b0001, 4'b0010);
    add(2'd3, 1'b1, 1'b0, 4'b1111, 1'b0);
    run(5, 4'b1111, 4'b0000); run(5, 4'b0000, 4'b1111); run(5, 4'b1111, 4'b0000);
    apply_all("a");
    repeat (2) @(posedge clk);
    #1;
    check("blink_hold", 4'b0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 4'b0001, 1'b0);
    @(negedge clk);
    check("rst_held", 4'b0001, 1'b0);
    rst_n = 1'b1;
    run(5, 4'b0001, 4'b0010); run(5, 4'b0010, 4'b0100);
    apply_all("b");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
